fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling buffer directly downstream of the program counter / instruction memory fetch path.
- Captures {pc, instruction} pairs produced each fetch cycle and presents them in order to the decode stage.
- Uses a valid/ready handshake on both sides, so fetch and decode can stall independently.
- Supports a one-cycle synchronous flush on a taken branch or jump, discarding wrong-path instructions.

Parameters:
DEPTH  4  number of entries; power of two, minimum 2
AW  32  address (pc) width in bits
IW  32  instruction width in bits

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-low
in_valid  input  1  fetch stage presents a valid {in_pc, in_instr}
in_ready  output  1  queue can accept an entry this cycle
in_pc  input  AW  address of fetched instruction
in_instr  input  IW  fetched instruction word
flush  input  1  discard all entries; asserted on taken branch/jump (PCSrc or Jump)
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head entry this cycle
out_pc  output  AW  pc of head entry
out_instr  output  IW  instruction of head entry
out_pc_plus4  output  AW  out_pc + 4, for branch/jump target formation downstream
count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
align_err  output  1  sticky flag: a pushed in_pc had bits [1:0] != 0

Behaviour:
- Reset (rst==0 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0, align_err=0.
  - Storage array is not cleared.
  - While rst is low: in_ready=0 and out_valid=0.
- Push occurs when in_valid && in_ready.
- Pop occurs when out_valid && out_ready.
- in_ready = rst && (count != DEPTH).
  - Combinational from registered count only; does not depend on out_ready.
  - There is no pass-through when full.
- out_valid = rst && (count != 0).
- First-word fall-through:
  - out_pc/out_instr are read combinationally from entry[rd_ptr].
  - An entry pushed at edge N is visible on out_* after edge N when the queue was empty. Latency is 1 cycle.
- When out_valid==0, out_pc, out_instr and out_pc_plus4 are driven to 0.
- out_pc_plus4 = out_pc + 4, truncated to AW bits (wraps, e.g. 0xFFFFFFFC -> 0x00000000).
  - When out_valid==0 it is 0, not 4.
- Pointer update:
  - On push, entry[wr_ptr] <= {in_pc, in_instr} and wr_ptr <= wr_ptr+1 mod DEPTH.
  - On pop, rd_ptr <= rd_ptr+1 mod DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, both pointers advance.
  - Legal when full: pop happens, push does not, since in_ready=0.
- Empty + out_ready: no pop, nothing changes.
- Full + in_valid: no push; the fetch stage must hold its data.
- Flush (flush==1 at posedge, rst==1):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Any same-cycle push and pop are both discarded; the array is not written.
  - out_valid=0 from the next cycle.
  - align_err is not cleared by flush.
- Priority: rst > flush > push/pop.
- align_err:
  - Set on any push with in_pc[1:0] != 2'b00; the entry is still stored normally.
  - Cleared only by reset.
- Reset asserted mid-operation: all entries are lost at that edge, identical to power-on reset.

Test Plan:
- Reset, then push pc=0x00000000/instr=0x20080005 with out_ready=0 -> next cycle out_valid=1, out_pc=0, out_instr=0x20080005, out_pc_plus4=0x4, count=1.
- Push 4 entries pc=0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0. A fifth in_valid is not accepted. Then hold out_ready=1 -> pops in order 0x0,0x4,0x8,0xC, then out_valid=0, outputs 0.
- Steady stream with in_valid=1 and out_ready=1 every cycle from empty -> count stays 1 after the first cycle, and order is preserved across pointer wrap (at least 10 entries).
- Queue holds 3 entries; assert flush with in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0. Then push pc=0x40 -> out_pc=0x40 next cycle.
- Push pc=0x00000006 -> align_err=1, entry delivered with out_pc=0x6. Then flush -> align_err still 1. Then rst=0 for one cycle -> align_err=0.
- Push pc=0xFFFFFFFC -> out_pc_plus4=0x00000000. Then with 2 entries queued, drive rst=0 -> next cycle count=0 and in_ready held 0 while rst=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: in-order {pc, instr} buffer with
// first-word fall-through, valid/ready on both sides and a one-cycle flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int IW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_pc,
    input  logic [IW-1:0]            in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_pc,
    output logic [IW-1:0]            out_instr,
    output logic [AW-1:0]            out_pc_plus4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     align_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] pc_mem  [DEPTH];
    logic [IW-1:0] ins_mem [DEPTH];

    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          push, pop;

    // Handshake uses registered count only: no pass-through when full.
    assign in_ready  = rst && (cnt_q != FULL);
    assign out_valid = rst && (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (push && (in_pc[1:0] != 2'b00)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Storage is never cleared; a flushed push must not write.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_q]  <= in_pc;
            ins_mem[wr_q] <= in_instr;
        end
    end

    assign out_pc       = out_valid ? pc_mem[rd_q]  : '0;
    assign out_instr    = out_valid ? ins_mem[rd_q] : '0;
    assign out_pc_plus4 = out_valid ? out_pc + AW'(4) : '0;
    assign count        = cnt_q;
    assign align_err    = err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of pushed entries,
// compared against the head whenever decode consumes.
module tb_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic [2:0]  count;
    logic        align_err;

    int   nchk = 0;
    int   nerr = 0;
    ent_t sb[$];
    int   mcnt = 0;
    logic merr = 1'b0;

    fetch_queue #(.DEPTH(4), .AW(32), .IW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_pc_plus4 (out_pc_plus4),
        .count        (count),
        .align_err    (align_err)
    );

    always #5 clk = ~clk;

    // Reference model update for the coming edge, then advance to the
    // following negedge where outputs are stable.
    task automatic cyc();
        bit   pu, po;
        ent_t e;
        pu = in_valid && rst && (mcnt != 4);
        po = out_ready && rst && (mcnt != 0);
        if (!rst) begin
            sb.delete();
            mcnt = 0;
            merr = 1'b0;
        end else if (flush) begin
            sb.delete();
            mcnt = 0;
        end else begin
            if (po) void'(sb.pop_front());
            if (pu) begin
                e.pc  = in_pc;
                e.ins = in_instr;
                sb.push_back(e);
                if (in_pc[1:0] != 2'b00) merr = 1'b1;
            end
            mcnt = sb.size();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        nchk++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        nchk++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        nchk++;
        if (count !== 3'd0 || align_err !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: count %0d err %b want 0 0",
                     count, align_err);
        end
        rst = 1'b1;
        cyc();
        nchk++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release: in_ready %b want 1", in_ready);
        end
    endtask

    task automatic test_first_word();
        in_valid  = 1'b1;
        in_pc     = 32'h0;
        in_instr  = 32'h2008_0005;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        nchk++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 ||
            out_instr !== 32'h2008_0005) begin
            nerr++;
            $display("FAIL fwft: v %b pc %h ins %h want 1 0 20080005",
                     out_valid, out_pc, out_instr);
        end
        nchk++;
        if (out_pc_plus4 !== 32'h4 || count !== 3'd1) begin
            nerr++;
            $display("FAIL fwft_p4_cnt: p4 %h cnt %0d want 4 1",
                     out_pc_plus4, count);
        end
        out_ready = 1'b1;
        nchk++;
        if (sb.size() == 0 || out_instr !== sb[0].ins) begin
            nerr++;
            $display("FAIL fwft_sb: ins %h sb size %0d", out_instr, sb.size());
        end
        cyc();
        out_ready = 1'b0;
        nchk++;
        if (out_valid !== 1'b0 || count !== 3'(mcnt)) begin
            nerr++;
            $display("FAIL fwft_drain: v %b cnt %0d want 0 %0d",
                     out_valid, count, mcnt);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(4 * i);
            in_instr = 32'hA000_0000 + 32'(i);
            cyc();
        end
        nchk++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL full: cnt %0d rdy %b want 4 0", count, in_ready);
        end
        in_pc    = 32'h10;
        in_instr = 32'hDEAD_BEEF;
        cyc();
        in_valid = 1'b0;
        nchk++;
        if (count !== 3'd4) begin
            nerr++;
            $display("FAIL full_no_push: cnt %0d want 4", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (out_valid !== 1'b1 || sb.size() == 0 ||
                out_pc !== sb[0].pc || out_pc !== 32'(4 * i) ||
                out_instr !== sb[0].ins) begin
                nerr++;
                $display("FAIL full_order[%0d]: v %b pc %h ins %h want pc %h",
                         i, out_valid, out_pc, out_instr, 32'(4 * i));
            end
            cyc();
        end
        out_ready = 1'b0;
        nchk++;
        if (out_valid !== 1'b0 || out_pc !== '0 || out_instr !== '0 ||
            out_pc_plus4 !== '0) begin
            nerr++;
            $display("FAIL empty_zero: v %b pc %h ins %h p4 %h want 0",
                     out_valid, out_pc, out_instr, out_pc_plus4);
        end
    endtask

    task automatic test_back_to_back();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_pc    = 32'h100 + 32'(4 * i);
            in_instr = 32'hB000_0000 + 32'(i);
            if (i > 0) begin
                nchk++;
                if (count !== 3'd1 || sb.size() == 0 ||
                    out_pc !== sb[0].pc ||
                    out_pc !== 32'h100 + 32'(4 * (i - 1)) ||
                    out_instr !== sb[0].ins) begin
                    nerr++;
                    $display("FAIL stream[%0d]: cnt %0d pc %h ins %h",
                             i, count, out_pc, out_instr);
                end
            end
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        nchk++;
        if (count !== 3'd0 || sb.size() != 0) begin
            nerr++;
            $display("FAIL stream_drain: cnt %0d want 0", count);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h300 + 32'(4 * i);
            in_instr = 32'hC000_0000 + 32'(i);
            cyc();
        end
        nchk++;
        if (count !== 3'd3) begin
            nerr++;
            $display("FAIL flush_pre: cnt %0d want 3", count);
        end
        in_pc     = 32'h200;
        out_ready = 1'b1;
        flush     = 1'b1;
        cyc();
        flush     = 1'b0;
        out_ready = 1'b0;
        nchk++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL flush: cnt %0d v %b want 0 0", count, out_valid);
        end
        in_pc    = 32'h40;
        in_instr = 32'hC0DE_0040;
        cyc();
        in_valid = 1'b0;
        nchk++;
        if (out_pc !== 32'h40 || count !== 3'd1 || out_pc !== sb[0].pc) begin
            nerr++;
            $display("FAIL flush_after: pc %h cnt %0d want 40 1",
                     out_pc, count);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_align();
        in_valid = 1'b1;
        in_pc    = 32'h6;
        in_instr = 32'h0000_0666;
        cyc();
        in_valid = 1'b0;
        nchk++;
        if (align_err !== 1'b1 || align_err !== merr || out_pc !== 32'h6) begin
            nerr++;
            $display("FAIL align_set: err %b pc %h want 1 6", align_err, out_pc);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        nchk++;
        if (align_err !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL align_flush: err %b v %b want 1 0",
                     align_err, out_valid);
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        nchk++;
        if (align_err !== 1'b0 || align_err !== merr) begin
            nerr++;
            $display("FAIL align_reset: err %b want 0", align_err);
        end
    endtask

    task automatic test_wrap_reset();
        in_valid = 1'b1;
        in_pc    = 32'hFFFF_FFFC;
        in_instr = 32'h1234_5678;
        cyc();
        nchk++;
        if (out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'h0) begin
            nerr++;
            $display("FAIL pc_wrap: pc %h p4 %h want fffffffc 0",
                     out_pc, out_pc_plus4);
        end
        in_pc = 32'h8000_0000;
        cyc();
        nchk++;
        if (count !== 3'd2 || count !== 3'(mcnt)) begin
            nerr++;
            $display("FAIL pre_reset: cnt %0d want 2", count);
        end
        rst = 1'b0;
        cyc();
        nchk++;
        if (count !== 3'd0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_pc !== '0) begin
            nerr++;
            $display("FAIL mid_reset: cnt %0d rdy %b v %b pc %h want 0",
                     count, in_ready, out_valid, out_pc);
        end
        cyc();
        nchk++;
        if (in_ready !== 1'b0 || count !== 3'd0) begin
            nerr++;
            $display("FAIL reset_hold: rdy %b cnt %0d want 0 0",
                     in_ready, count);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        nchk++;
        if (count !== 3'd0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL post_reset: cnt %0d rdy %b want 0 1",
                     count, in_ready);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_word();
        test_full();
        test_back_to_back();
        test_flush();
        test_align();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
